// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose:
//   Countdown-scoreboard hazard unit placed between the ID stage and the
//   IF/ID and ID/EX pipeline registers. Every architectural register has a
//   small counter giving the remaining cycles until its in-flight writer's
//   result becomes forwardable. The condition flags have one more counter of
//   the same kind. The ID instruction is held (PC and IF/ID frozen, a bubble
//   sent into ID/EX) while any operand or flag it reads is still counting
//   down. A taken branch resolved in EX squashes both IF/ID and ID/EX and
//   overrides any stall.
//   A watchdog raises a sticky error when one continuous stall reaches
//   MAX_STALL cycles.
//
// Optional feature (macro HAZARD_PERF_EN):
//   When defined, a 16-bit saturating output stall_cycles counts the cycles
//   spent stalling. When undefined, the port and counter are absent.
//
// Ports:
//   clk             pipeline clock, rising edge
//   rst_n           asynchronous active-low reset
//   id_valid        ID stage holds a real instruction
//   id_rs1_en/rs1   first source register read enable / index
//   id_rs2_en/rs2   second source register read enable / index
//   id_rd_we/rd     destination register write enable / index
//   id_is_load      ID instruction is a memory load
//   id_sets_flags   ID instruction writes the condition flags
//   id_uses_flags   ID instruction is a flag-reading conditional branch
//   ex_branch_taken branch resolved taken in EX this cycle
//   pc_write        PC update enable
//   if_write        IF/ID register load enable
//   idex_flush      insert a bubble into ID/EX
//   ifid_flush      squash the IF/ID contents
//   stall_err       sticky watchdog error
//   stall_cycles    stall cycle counter (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
   parameter int NUM_REGS  = 8,
   parameter int REG_AW    = 3,
   parameter int LOAD_LAT  = 1,
   parameter int FLAG_LAT  = 1,
   parameter int MAX_STALL = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_rs1_en,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs2_en,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rd_we,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_load,
   input  logic              id_sets_flags,
   input  logic              id_uses_flags,
   input  logic              ex_branch_taken,
   output logic              pc_write,
   output logic              if_write,
   output logic              idex_flush,
   output logic              ifid_flush,
   output logic              stall_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   // Stall length counter is at least 4 bits and wide enough for MAX_STALL.
   localparam int SLW = ($clog2(MAX_STALL + 1) > 4) ? $clog2(MAX_STALL + 1) : 4;

   localparam logic [2:0]     LOAD_V = 3'(LOAD_LAT);
   localparam logic [2:0]     FLAG_V = 3'(FLAG_LAT);
   localparam logic [SLW-1:0] MAX_V  = SLW'(MAX_STALL);

   typedef enum logic {RUN, STALL} state_t;

   logic [2:0]     cnt [NUM_REGS];
   logic [2:0]     flag_cnt;
   state_t         state;
   logic [SLW-1:0] stall_len;
   logic [SLW-1:0] stall_len_nxt;

   logic rs1_busy;
   logic rs2_busy;
   logic hz;
   logic stall_now;
   logic issue;

   // ---------------------------------------------------------------------------
   // Hazard detection. Only the counters as they stand before this edge are
   // consulted, so an instruction reading and writing the same register sees
   // the previous writer, never itself.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (id_rs1 == REG_AW'(r) && cnt[r] != 3'd0) rs1_busy = 1'b1;
         if (id_rs2 == REG_AW'(r) && cnt[r] != 3'd0) rs2_busy = 1'b1;
      end
      hz = id_valid & ((id_rs1_en & rs1_busy) |
                       (id_rs2_en & rs2_busy) |
                       (id_uses_flags & (flag_cnt != 3'd0)));
      stall_now = hz & ~ex_branch_taken;
      issue     = id_valid & ~hz & ~ex_branch_taken;
   end

   // Pipeline controls; a taken branch overrides a stall.
   always_comb begin
      pc_write   = 1'b1;
      if_write   = 1'b1;
      idex_flush = 1'b0;
      ifid_flush = 1'b0;
      if (ex_branch_taken) begin
         idex_flush = 1'b1;
         ifid_flush = 1'b1;
      end else if (hz) begin
         pc_write   = 1'b0;
         if_write   = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Register and flag scoreboard. A newly issued writer replaces whatever the
   // counter held: a load restarts the countdown, while an ALU writer clears
   // it because its result forwards straight from EX.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counter array is architectural state that must start
         // clear, so it is reset element by element rather than left to power-up.
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= 3'd0;
         flag_cnt <= 3'd0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (issue && id_rd_we && id_rd == REG_AW'(r)) begin
               cnt[r] <= id_is_load ? LOAD_V : 3'd0;
            end else if (cnt[r] != 3'd0) begin
               // NOTE: sequential state uses non-blocking assignment so all
               // registers update together from pre-edge values.
               cnt[r] <= cnt[r] - 3'd1;
            end
         end
         if (issue && id_sets_flags) begin
            flag_cnt <= id_is_load ? LOAD_V : FLAG_V;
         end else if (flag_cnt != 3'd0) begin
            flag_cnt <= flag_cnt - 3'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stall tracking FSM and watchdog. stall_len counts the cycles of the
   // current stall; the error is raised on the edge where it reaches the limit.
   // ---------------------------------------------------------------------------
   always_comb begin
      stall_len_nxt = '0;
      if (stall_now) begin
         if (state == RUN)           stall_len_nxt = SLW'(1);
         else if (stall_len == '1)   stall_len_nxt = stall_len;
         else                        stall_len_nxt = stall_len + SLW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         stall_len <= '0;
         stall_err <= 1'b0;
      end else begin
         case (state)
            RUN:     if (stall_now)  state <= STALL;
            STALL:   if (!stall_now) state <= RUN;
            default: state <= RUN;
         endcase
         stall_len <= stall_len_nxt;
         if (stall_len_nxt >= MAX_V) stall_err <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 16'd0;
      end else if (stall_now && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// Bench for hazard_scoreboard_unit. Three instances with different latencies
// share one stimulus stream:
//   u0: LOAD_LAT=1 FLAG_LAT=1 MAX_STALL=15
//   u1: LOAD_LAT=2 FLAG_LAT=0 MAX_STALL=15
//   u2: LOAD_LAT=7 FLAG_LAT=3 MAX_STALL=6
// A continuous stall can never outlast the 3-bit counters (7 cycles), so the
// watchdog is exercised on u2 with a short limit.
// The reference keeps, per register and for the flags, the cycle number at
// which the last writer's result becomes forwardable.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_rs1_en, id_rs2_en, id_rd_we;
   logic [2:0] id_rs1, id_rs2, id_rd;
   logic       id_is_load, id_sets_flags, id_uses_flags, ex_branch_taken;

   logic pc_write [3];
   logic if_write [3];
   logic idex_flush [3];
   logic ifid_flush [3];
   logic stall_err [3];
`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cycles [3];
`endif

   always #5 clk = ~clk;

   hazard_scoreboard_unit #(.NUM_REGS(8), .REG_AW(3), .LOAD_LAT(1), .FLAG_LAT(1), .MAX_STALL(15)) u0 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_en(id_rs1_en), .id_rs1(id_rs1), .id_rs2_en(id_rs2_en), .id_rs2(id_rs2),
      .id_rd_we(id_rd_we), .id_rd(id_rd), .id_is_load(id_is_load),
      .id_sets_flags(id_sets_flags), .id_uses_flags(id_uses_flags),
      .ex_branch_taken(ex_branch_taken),
      .pc_write(pc_write[0]), .if_write(if_write[0]), .idex_flush(idex_flush[0]),
      .ifid_flush(ifid_flush[0]), .stall_err(stall_err[0])
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles[0])
`endif
   );

   hazard_scoreboard_unit #(.NUM_REGS(8), .REG_AW(3), .LOAD_LAT(2), .FLAG_LAT(0), .MAX_STALL(15)) u1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_en(id_rs1_en), .id_rs1(id_rs1), .id_rs2_en(id_rs2_en), .id_rs2(id_rs2),
      .id_rd_we(id_rd_we), .id_rd(id_rd), .id_is_load(id_is_load),
      .id_sets_flags(id_sets_flags), .id_uses_flags(id_uses_flags),
      .ex_branch_taken(ex_branch_taken),
      .pc_write(pc_write[1]), .if_write(if_write[1]), .idex_flush(idex_flush[1]),
      .ifid_flush(ifid_flush[1]), .stall_err(stall_err[1])
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles[1])
`endif
   );

   hazard_scoreboard_unit #(.NUM_REGS(8), .REG_AW(3), .LOAD_LAT(7), .FLAG_LAT(3), .MAX_STALL(6)) u2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_en(id_rs1_en), .id_rs1(id_rs1), .id_rs2_en(id_rs2_en), .id_rs2(id_rs2),
      .id_rd_we(id_rd_we), .id_rd(id_rd), .id_is_load(id_is_load),
      .id_sets_flags(id_sets_flags), .id_uses_flags(id_uses_flags),
      .ex_branch_taken(ex_branch_taken),
      .pc_write(pc_write[2]), .if_write(if_write[2]), .idex_flush(idex_flush[2]),
      .ifid_flush(ifid_flush[2]), .stall_err(stall_err[2])
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles[2])
`endif
   );

   function automatic int load_lat(input int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 7;
   endfunction
   function automatic int flag_lat(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 3;
   endfunction
   function automatic int max_stall(input int i);
      return (i == 2) ? 6 : 15;
   endfunction

   // ---------------------------------------------------------------------------
   // Checking bookkeeping
   // ---------------------------------------------------------------------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: cycle index and "forwardable from cycle" per register.
   // ---------------------------------------------------------------------------
   int cyc = 0;
   int rdy [3][8];
   int frdy [3];
   int run_len [3];
   bit err_m [3];
   int perf_m [3];

   function automatic bit model_hz(input int i);
      return id_valid && ((id_rs1_en && cyc < rdy[i][id_rs1]) ||
                          (id_rs2_en && cyc < rdy[i][id_rs2]) ||
                          (id_uses_flags && cyc < frdy[i]));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 8; r++) rdy[i][r] <= 0;
            frdy[i]    <= 0;
            run_len[i] <= 0;
            err_m[i]   <= 1'b0;
            perf_m[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (model_hz(i) && !ex_branch_taken) begin
               run_len[i] <= run_len[i] + 1;
               if (run_len[i] + 1 >= max_stall(i)) err_m[i] <= 1'b1;
               if (perf_m[i] < 65535) perf_m[i] <= perf_m[i] + 1;
            end else begin
               run_len[i] <= 0;
            end
            if (id_valid && !model_hz(i) && !ex_branch_taken) begin
               if (id_rd_we)
                  rdy[i][id_rd] <= id_is_load ? cyc + load_lat(i) + 1 : cyc + 1;
               if (id_sets_flags)
                  frdy[i] <= cyc + (id_is_load ? load_lat(i) : flag_lat(i)) + 1;
            end
         end
      end
   end

   // One compare process: every negedge, all instances against the model.
   always @(negedge clk) begin
      logic h;
      logic [4:0] exp_v;
      for (int i = 0; i < 3; i++) begin
         h = model_hz(i);
         if (ex_branch_taken)  exp_v = {1'b1, 1'b1, 1'b1, 1'b1, err_m[i]};
         else if (h)           exp_v = {1'b0, 1'b0, 1'b1, 1'b0, err_m[i]};
         else                  exp_v = {1'b1, 1'b1, 1'b0, 1'b0, err_m[i]};
         check($sformatf("u%0d pc/if/idex/ifid/err cyc %0d", i, cyc),
               16'({pc_write[i], if_write[i], idex_flush[i], ifid_flush[i], stall_err[i]}),
               16'(exp_v));
`ifdef HAZARD_PERF_EN
         check($sformatf("u%0d stall_cycles cyc %0d", i, cyc), stall_cycles[i], 16'(perf_m[i]));
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   int stalls [3];

   task automatic clear_in();
      id_valid = 0; id_rs1_en = 0; id_rs1 = 0; id_rs2_en = 0; id_rs2 = 0;
      id_rd_we = 0; id_rd = 0; id_is_load = 0; id_sets_flags = 0;
      id_uses_flags = 0; ex_branch_taken = 0;
   endtask

   // Present an instruction: reads rs1 if r1>=0, rs2 if r2>=0, writes rd if rd>=0.
   task automatic instr(input int r1, input int r2, input int rd,
                        input bit ld, input bit sf, input bit uf);
      clear_in();
      id_valid      = 1;
      id_rs1_en     = (r1 >= 0); id_rs1 = 3'(r1 < 0 ? 0 : r1);
      id_rs2_en     = (r2 >= 0); id_rs2 = 3'(r2 < 0 ? 0 : r2);
      id_rd_we      = (rd >= 0); id_rd  = 3'(rd < 0 ? 0 : rd);
      id_is_load    = ld;
      id_sets_flags = sf;
      id_uses_flags = uf;
   endtask

   // One cycle: sample stall at negedge, then advance past the next posedge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (!pc_write[i]) stalls[i]++;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      clear_in();
      repeat (n) tick();
   endtask

   task automatic reset_stalls();
      for (int i = 0; i < 3; i++) stalls[i] = 0;
   endtask

   task automatic check_stalls(input string name, input int e0, input int e1, input int e2);
      check({name, " u0"}, 16'(stalls[0]), 16'(e0));
      check({name, " u1"}, 16'(stalls[1]), 16'(e1));
      check({name, " u2"}, 16'(stalls[2]), 16'(e2));
   endtask

   // ---------------------------------------------------------------------------
   // Directed scenarios, then randomized traffic
   // ---------------------------------------------------------------------------
   initial begin
      clear_in();
      repeat (2) @(posedge clk);
      #2 rst_n = 1;

      // Reset state
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         check($sformatf("reset outputs u%0d", i),
               16'({pc_write[i], if_write[i], idex_flush[i], ifid_flush[i], stall_err[i]}),
               16'(5'b11000));
      @(posedge clk); #2;

      // Load r1, then a reader of r1: LOAD_LAT stall cycles each
      idle(2);
      instr(-1, -1, 1, 1, 0, 0); tick();
      reset_stalls();
      instr(1, -1, -1, 0, 0, 0); repeat (9) tick();
      check_stalls("load-use r1 stalls", 1, 2, 7);
      check("watchdog u0", 16'(stall_err[0]), 16'd0);
      check("watchdog u1", 16'(stall_err[1]), 16'd0);
      check("watchdog u2", 16'(stall_err[2]), 16'd1);

      // Load r3, dependent via rs2
      idle(8);
      instr(-1, -1, 3, 1, 0, 0); tick();
      reset_stalls();
      instr(-1, 3, 0, 0, 0, 0); repeat (9) tick();
      check_stalls("load-use r3 stalls", 1, 2, 7);

      // Load r3, independent reader of r4
      idle(8);
      instr(-1, -1, 3, 1, 0, 0); tick();
      reset_stalls();
      instr(4, -1, -1, 0, 0, 0); repeat (3) tick();
      check_stalls("independent r4 stalls", 0, 0, 0);

      // Compare then branch: FLAG_LAT stalls
      idle(8);
      instr(5, 6, -1, 0, 1, 0); tick();
      reset_stalls();
      instr(-1, -1, -1, 0, 0, 1); repeat (9) tick();
      check_stalls("cmp-branch stalls", 1, 0, 3);

      // Flag-setting load then branch: LOAD_LAT stalls
      idle(8);
      instr(-1, -1, -1, 1, 1, 0); tick();
      reset_stalls();
      instr(-1, -1, -1, 0, 0, 1); repeat (9) tick();
      check_stalls("load-flags branch stalls", 1, 2, 7);

      // Supersede: load r2, ALU write r2, read r2
      idle(8);
      instr(-1, -1, 2, 1, 0, 0); tick();
      reset_stalls();
      instr(0, -1, 2, 0, 0, 0); tick();
      check_stalls("alu writer after load stalls", 0, 0, 0);
      reset_stalls();
      instr(2, 2, -1, 0, 0, 0); repeat (3) tick();
      check_stalls("read after supersede stalls", 0, 0, 0);

      // Taken branch while stalled: the stalled load to r6 must be discarded
      idle(8);
      instr(-1, -1, 5, 1, 0, 0); tick();
      instr(5, -1, 6, 1, 0, 0); tick();
      ex_branch_taken = 1;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         check($sformatf("branch over stall u%0d", i),
               16'({pc_write[i], if_write[i], idex_flush[i], ifid_flush[i]}), 16'(4'b1111));
      @(posedge clk); #2;
      reset_stalls();
      instr(6, -1, -1, 0, 0, 0); tick();
      check_stalls("discarded writer r6 stalls", 0, 0, 0);

      idle(10);
      check("watchdog sticky u2", 16'(stall_err[2]), 16'd1);

      // Reset pulse in the middle of a stall
      instr(-1, -1, 1, 1, 0, 0); tick();
      instr(1, -1, -1, 0, 0, 0); tick();
      #1 check("stalled before reset u1", 16'(pc_write[1]), 16'd0);
      rst_n = 0;
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("async reset outputs u%0d", i),
               16'({pc_write[i], if_write[i], idex_flush[i], ifid_flush[i], stall_err[i]}),
               16'(5'b11000));
      @(posedge clk); #2 rst_n = 1;
      idle(3);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         clear_in();
         id_valid        = ($urandom_range(0, 99) < 80);
         id_rs1_en       = $urandom_range(0, 1);
         id_rs1          = 3'($urandom_range(0, 7));
         id_rs2_en       = $urandom_range(0, 1);
         id_rs2          = 3'($urandom_range(0, 7));
         id_rd_we        = ($urandom_range(0, 99) < 60);
         id_rd           = 3'($urandom_range(0, 7));
         id_is_load      = ($urandom_range(0, 99) < 35);
         id_sets_flags   = ($urandom_range(0, 99) < 25);
         id_uses_flags   = ($urandom_range(0, 99) < 20);
         ex_branch_taken = ($urandom_range(0, 99) < 8);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
